fp16_argmax_classifier: RTL and testbench

//   Downstream consumer of fp16_softmax. Captures the IN_OUT_NUM fp16 softmax outputs when the softmax valid is high.

---
 rtl/fp16_argmax_classifier.sv | 160 ++++++++++++++++
 tb/tb_fp16_argmax_classifier.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp16_argmax_classifier.sv
// Captures one fp16 softmax vector, scans it one lane per cycle and reports the
// argmax lane, its value, a low-confidence flag and a NaN-seen flag on valid/ready.
module fp16_argmax_classifier #(
   parameter int          IN_OUT_NUM  = 10,
   parameter int          IDX_W       = $clog2(IN_OUT_NUM),
   parameter logic [15:0] CONF_THRESH = 16'h3400
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     sm_valid,
   input  logic [IN_OUT_NUM*16-1:0] sm_out,
   output logic                     sm_clear,
   output logic                     busy,
   output logic                     res_valid,
   input  logic                     res_ready,
   output logic [IDX_W-1:0]         class_idx,
   output logic [15:0]              max_val,
   output logic                     low_conf,
   output logic                     nan_seen
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_SCAN,
      S_DONE
   } state_t;

   localparam logic [15:0] NAN_CANON = 16'h7E00;

   function automatic logic is_nan(input logic [15:0] v);
      return (v[14:10] == 5'h1F) && (v[9:0] != 10'd0);
   endfunction

   // Monotonic ordering key: NaN is 0 (below all numbers), negatives count down
   // by magnitude, -0 folds onto +0, positives count up by magnitude.
   function automatic logic [16:0] rank_key(input logic [15:0] v);
      logic [16:0] k;
      if (is_nan(v)) begin
         k = 17'd0;
      end else if (!v[15] || (v[14:0] == 15'd0)) begin
         k = {2'b11, v[14:0]};
      end else begin
         k = {2'b10, ~v[14:0]};
      end
      return k;
   endfunction

   state_t                   r_state;
   logic [IN_OUT_NUM*16-1:0] r_buf;
   logic [IDX_W-1:0]         r_cnt;
   logic [16:0]              r_best_key;
   logic [15:0]              r_best_val;
   logic [IDX_W-1:0]         r_best_idx;
   logic                     r_nan;
   logic                     r_sm_clear;
   logic                     r_busy;
   logic                     r_res_valid;
   logic [IDX_W-1:0]         r_class_idx;
   logic [15:0]              r_max_val;
   logic                     r_low_conf;
   logic                     r_nan_seen;

   logic [15:0] w_lanes [IN_OUT_NUM];
   logic [15:0] w_lane;
   logic [16:0] w_lane_key;
   logic [16:0] w_thresh_key;
   logic        w_take;
   logic        w_last;

   genvar gi;
   generate
      for (gi = 0; gi < IN_OUT_NUM; gi++) begin : g_lane
         assign w_lanes[gi] = r_buf[gi*16 +: 16];
      end
   endgenerate

   assign w_lane       = w_lanes[r_cnt];
   assign w_lane_key   = rank_key(w_lane);
   assign w_thresh_key = rank_key(CONF_THRESH);
   // Best key starts at 0, so lane 0 loads unless NaN and ties keep the lower index.
   assign w_take       = (w_lane_key > r_best_key);
   assign w_last       = (r_cnt == IDX_W'(IN_OUT_NUM - 1));

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= S_IDLE;
         r_buf       <= '0;
         r_cnt       <= '0;
         r_best_key  <= '0;
         r_best_val  <= 16'h0000;
         r_best_idx  <= '0;
         r_nan       <= 1'b0;
         r_sm_clear  <= 1'b0;
         r_busy      <= 1'b0;
         r_res_valid <= 1'b0;
         r_class_idx <= '0;
         r_max_val   <= 16'h0000;
         r_low_conf  <= 1'b0;
         r_nan_seen  <= 1'b0;
      end else begin
         r_sm_clear <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (sm_valid) begin
                  r_buf      <= sm_out;
                  r_cnt      <= '0;
                  r_best_key <= '0;
                  r_best_val <= NAN_CANON;
                  r_best_idx <= '0;
                  r_nan      <= 1'b0;
                  r_sm_clear <= 1'b1;
                  r_busy     <= 1'b1;
                  r_state    <= S_SCAN;
               end
            end
            S_SCAN: begin
               if (w_take) begin
                  r_best_key <= w_lane_key;
                  r_best_val <= w_lane;
                  r_best_idx <= r_cnt;
               end
               if (is_nan(w_lane)) begin
                  r_nan <= 1'b1;
               end
               if (w_last) begin
                  r_state <= S_DONE;
               end else begin
                  r_cnt <= r_cnt + IDX_W'(1);
               end
            end
            S_DONE: begin
               // First DONE cycle publishes the result; outputs then hold until accepted.
               if (!r_res_valid) begin
                  r_res_valid <= 1'b1;
                  r_class_idx <= r_best_idx;
                  r_max_val   <= r_best_val;
                  r_low_conf  <= (r_best_key < w_thresh_key);
                  r_nan_seen  <= r_nan;
               end else if (res_ready) begin
                  r_res_valid <= 1'b0;
                  r_busy      <= 1'b0;
                  r_state     <= S_IDLE;
               end
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign sm_clear  = r_sm_clear;
   assign busy      = r_busy;
   assign res_valid = r_res_valid;
   assign class_idx = r_class_idx;
   assign max_val   = r_max_val;
   assign low_conf  = r_low_conf;
   assign nan_seen  = r_nan_seen;

endmodule

// File: tb/tb_fp16_argmax_classifier.sv
// Scoreboard bench for fp16_argmax_classifier: directed cases plus random vectors
// checked against a real-valued argmax model.
module tb_fp16_argmax_classifier;

   localparam int N     = 10;
   localparam int IDX_W = $clog2(N);
   localparam int W     = N * 16;

   logic             clk;
   logic             reset;
   logic             sm_valid;
   logic [W-1:0]     sm_out;
   logic             sm_clear;
   logic             busy;
   logic             res_valid;
   logic             res_ready;
   logic [IDX_W-1:0] class_idx;
   logic [15:0]      max_val;
   logic             low_conf;
   logic             nan_seen;

   fp16_argmax_classifier #(
      .IN_OUT_NUM (N),
      .IDX_W      (IDX_W),
      .CONF_THRESH(16'h3400)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .sm_valid (sm_valid),
      .sm_out   (sm_out),
      .sm_clear (sm_clear),
      .busy     (busy),
      .res_valid(res_valid),
      .res_ready(res_ready),
      .class_idx(class_idx),
      .max_val  (max_val),
      .low_conf (low_conf),
      .nan_seen (nan_seen)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int          idx;
      logic [15:0] val;
      bit          low;
      bit          nan;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_pass   = 0;
   int   n_clear  = 0;
   int   n_capt   = 0;
   int   n_res    = 0;

   task automatic chk(input string name, input longint got, input longint want);
      n_checks++;
      if (got == want) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, got, want);
   endtask

   // ---------------- reference model ----------------
   function automatic bit fp_is_nan(input logic [15:0] h);
      return (h[14:10] == 5'h1F) && (h[9:0] != 10'd0);
   endfunction

   function automatic real fp16_to_real(input logic [15:0] h);
      int  e;
      int  m;
      real mag;
      e = int'(h[14:10]);
      m = int'(h[9:0]);
      if (e == 31)     mag = 1.0e30;
      else if (e == 0) mag = real'(m) / 16777216.0;
      else             mag = real'(1024 + m) * (2.0 ** (e - 25));
      return h[15] ? -mag : mag;
   endfunction

   function automatic exp_t model(input logic [W-1:0] v);
      exp_t        e;
      int          best_i;
      real         best_r;
      real         r;
      logic [15:0] h;
      best_i = -1;
      best_r = 0.0;
      e.nan  = 1'b0;
      for (int i = 0; i < N; i++) begin
         h = v[i*16 +: 16];
         if (fp_is_nan(h)) begin
            e.nan = 1'b1;
         end else begin
            r = fp16_to_real(h);
            if (best_i < 0 || r > best_r) begin
               best_i = i;
               best_r = r;
            end
         end
      end
      if (best_i < 0) begin
         e.idx = 0;
         e.val = 16'h7E00;
         e.low = 1'b1;
      end else begin
         e.idx = best_i;
         e.val = v[best_i*16 +: 16];
         e.low = (best_r < 0.25);
      end
      return e;
   endfunction

   // ---------------- monitor ----------------
   always @(negedge clk) begin
      if (sm_clear) n_clear++;
   end

   always @(negedge clk) begin
      exp_t e;
      if (!reset && res_valid && res_ready) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_result", 1, 0);
         end else begin
            e = exp_q.pop_front();
            n_res++;
            $display("result %0d: idx=%0d max=%04h low=%0b nan=%0b (want idx=%0d max=%04h low=%0b nan=%0b)",
                     n_res, class_idx, max_val, low_conf, nan_seen, e.idx, e.val, e.low, e.nan);
            chk("class_idx", longint'(class_idx), longint'(e.idx));
            chk("max_val",   longint'(max_val),   longint'(e.val));
            chk("low_conf",  longint'(low_conf),  longint'(e.low));
            chk("nan_seen",  longint'(nan_seen),  longint'(e.nan));
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic wait_idle();
      int cyc;
      cyc = 0;
      while ((busy || res_valid) && cyc < 200) begin
         @(posedge clk); #1;
         cyc++;
      end
      if (cyc >= 200) chk("idle_timeout", 1, 0);
   endtask

   task automatic run_vec(input logic [W-1:0] v, input int stall, input bit reassert,
                          input logic [W-1:0] v2);
      int               lat;
      logic [IDX_W-1:0] s_idx;
      logic [15:0]      s_val;
      bit               s_low;
      bit               s_nan;
      bit               stable;
      wait_idle();
      exp_q.push_back(model(v));
      sm_out   = v;
      sm_valid = 1'b1;
      @(posedge clk); #1;
      n_capt++;
      chk("clear_pulse", longint'(sm_clear), 1);
      sm_valid = 1'b0;
      lat = 0;
      while (!res_valid && lat < 100) begin
         @(posedge clk); #1;
         lat++;
      end
      chk("latency", lat, N + 1);
      if (stall > 0) begin
         s_idx  = class_idx;
         s_val  = max_val;
         s_low  = low_conf;
         s_nan  = nan_seen;
         stable = 1'b1;
         if (reassert) begin
            sm_out   = v2;
            sm_valid = 1'b1;
         end
         for (int c = 0; c < stall; c++) begin
            @(posedge clk); #1;
            if (!res_valid || class_idx != s_idx || max_val != s_val ||
                low_conf != s_low || nan_seen != s_nan) stable = 1'b0;
         end
         chk("stall_stable", longint'(stable), 1);
      end
      res_ready = 1'b1;
      @(posedge clk); #1;
      res_ready = 1'b0;
      chk("accept_drop", longint'(res_valid), 0);
   endtask

   function automatic logic [15:0] rand_lane(input logic [W-1:0] sofar, input int i);
      int sel;
      sel = $urandom_range(0, 9);
      case (sel)
         0, 1, 2, 3, 4: return {1'b0, 15'($urandom_range(0, 16'h3C00))};
         5:             return {1'b1, 15'($urandom_range(0, 16'h7BFF))};
         6:             return {1'($urandom_range(0, 1)), 15'd0};
         7:             return {1'($urandom_range(0, 1)), 15'h7C00};
         8:             return {1'($urandom_range(0, 1)), 5'h1F, 10'($urandom_range(1, 1023))};
         default:       return (i > 0) ? sofar[($urandom_range(0, i - 1))*16 +: 16] : 16'h3555;
      endcase
   endfunction

   function automatic logic [W-1:0] rand_vec();
      logic [W-1:0] v;
      v = '0;
      for (int i = 0; i < N; i++) v[i*16 +: 16] = rand_lane(v, i);
      return v;
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [W-1:0] v;
      logic [W-1:0] v2;
      logic [W-1:0] t1;

      reset     = 1'b1;
      sm_valid  = 1'b0;
      sm_out    = '0;
      res_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      chk("rst_sm_clear",  longint'(sm_clear),  0);
      chk("rst_busy",      longint'(busy),      0);
      chk("rst_res_valid", longint'(res_valid), 0);
      chk("rst_class_idx", longint'(class_idx), 0);
      chk("rst_max_val",   longint'(max_val),   0);
      chk("rst_low_nan",   longint'({low_conf, nan_seen}), 0);

      // T1
      t1 = '0;
      t1[0*16 +: 16] = 16'h3800;
      t1[1*16 +: 16] = 16'h3000;
      t1[2*16 +: 16] = 16'h3400;
      t1[3*16 +: 16] = 16'h2C00;
      run_vec(t1, 0, 1'b0, '0);

      // T2: tie keeps the lowest index
      for (int i = 0; i < N; i++) v[i*16 +: 16] = 16'h3000;
      v[3*16 +: 16] = 16'h3C00;
      v[7*16 +: 16] = 16'h3C00;
      run_vec(v, 0, 1'b0, '0);

      // T3: all negative
      for (int i = 0; i < N; i++) v[i*16 +: 16] = (i % 2 == 1) ? 16'hC000 : 16'hBC00;
      v[5*16 +: 16] = 16'hB800;
      run_vec(v, 0, 1'b0, '0);

      // T4: NaN lane, signed zeros, then all NaN
      for (int i = 0; i < N; i++) v[i*16 +: 16] = (i % 2 == 1) ? 16'h8000 : 16'h0000;
      v[2*16 +: 16] = 16'h7E00;
      v[9*16 +: 16] = 16'h3A00;
      run_vec(v, 0, 1'b0, '0);
      for (int i = 0; i < N; i++) v[i*16 +: 16] = 16'h7E00;
      v[3*16 +: 16] = 16'hFC01;
      run_vec(v, 0, 1'b0, '0);

      // Zero tie: -0 in lane 0 beats a later +0
      v = '0;
      v[0*16 +: 16] = 16'h8000;
      for (int i = 1; i < N; i++) v[i*16 +: 16] = 16'hFC00;
      v[4*16 +: 16] = 16'h0000;
      run_vec(v, 0, 1'b0, '0);

      // T5: long stall with sm_valid re-asserted, then that vector is captured
      v  = rand_vec();
      v2 = rand_vec();
      run_vec(v, 20, 1'b1, v2);
      run_vec(v2, 0, 1'b0, '0);

      // T6: reset at scan count 4 discards the partial result
      wait_idle();
      v = rand_vec();
      sm_out   = v;
      sm_valid = 1'b1;
      @(posedge clk); #1;
      n_capt++;
      sm_valid = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      chk("midscan_rst_res_valid", longint'(res_valid), 0);
      chk("midscan_rst_busy",      longint'(busy),      0);
      chk("midscan_rst_max_val",   longint'(max_val),   0);
      run_vec(t1, 0, 1'b0, '0);

      // Random vectors
      for (int n = 0; n < 30; n++) begin
         v = rand_vec();
         run_vec(v, $urandom_range(0, 3), 1'b0, '0);
      end

      repeat (3) @(posedge clk);
      #1;
      chk("queue_empty",  exp_q.size(), 0);
      chk("clear_pulses", n_clear, n_capt);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
